// File: rtl/task_link_ctrl.sv
// Link supervisor between the task layer and the mhp protocol engine: send/done/err exchanges,
// timeout, retry limit, heartbeat refresh and a sticky fault. Define TASK_LINK_BACKOFF_EN for retry backoff.
module task_link_ctrl #(
  parameter int unsigned TIMEOUT_CYC   = 1000,
  parameter int unsigned HEARTBEAT_CYC = 100000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned BACKOFF_CYC   = 64,
  parameter int unsigned CNT_W         = 20
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_enable,
  output logic                           o_send,
  input  logic                           i_done,
  input  logic                           i_err,
  output logic                           o_link,
  output logic                           o_fail,
  output logic [2:0]                     o_state,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HbLast      = CNT_W'(HEARTBEAT_CYC - 1);
  localparam logic [RW-1:0]    RetryOne    = RW'(1);
  localparam logic [RW-1:0]    RetryMax    = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT    = 3'd2,
    LINKED  = 3'd3,
`ifdef TASK_LINK_BACKOFF_EN
    FAULT   = 3'd4,
    BACKOFF = 3'd5
`else
    FAULT   = 3'd4
`endif
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  timer_q;
  logic [RW-1:0]     retry_q;
  logic              link_q;
  logic              send_q;
  logic              fail_q;
  logic [RW-1:0]     retry_inc;

  assign retry_inc = (retry_q == RetryMax) ? retry_q : retry_q + RetryOne;

`ifdef TASK_LINK_BACKOFF_EN
  // Backoff doubles per consecutive failure: BACKOFF_CYC << (retry-1) cycles in BACKOFF.
  logic [CNT_W-1:0] backoff_last;
  assign backoff_last = (CNT_W'(BACKOFF_CYC) << (retry_q - RetryOne)) - CntOne;
`else
  logic unused_backoff_cfg;
  assign unused_backoff_cfg = ^CNT_W'(BACKOFF_CYC);
`endif

  // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      link_q  <= 1'b0;
      send_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      send_q <= 1'b0;
      if (!i_enable) begin
        state_q <= IDLE;
        timer_q <= '0;
        retry_q <= '0;
        link_q  <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= SEND;
          SEND: begin
            send_q  <= 1'b1;
            timer_q <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            if (i_done) begin
              state_q <= LINKED;
              retry_q <= '0;
              link_q  <= 1'b1;
              timer_q <= '0;
            end else if (i_err || timer_q == TimeoutLast) begin
              retry_q <= retry_inc;
              timer_q <= '0;
              if (retry_inc == RetryMax) begin
                state_q <= FAULT;
                link_q  <= 1'b0;
                fail_q  <= 1'b1;
              end else begin
`ifdef TASK_LINK_BACKOFF_EN
                state_q <= BACKOFF;
`else
                state_q <= SEND;
`endif
              end
            end else begin
              timer_q <= timer_q + CntOne;
            end
          end
          LINKED: begin
            if (i_done) begin
              timer_q <= '0;
            end else if (timer_q == HbLast) begin
              state_q <= SEND;
            end else begin
              timer_q <= timer_q + CntOne;
            end
          end
          FAULT: ;
`ifdef TASK_LINK_BACKOFF_EN
          BACKOFF: begin
            if (timer_q == backoff_last) begin
              state_q <= SEND;
            end else begin
              timer_q <= timer_q + CntOne;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            link_q  <= 1'b0;
            fail_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_send  = send_q;
  assign o_link  = link_q;
  assign o_fail  = fail_q;
  assign o_state = state_q;
  assign o_retry = retry_q;

endmodule

// File: tb/tb_task_link_ctrl.sv
// Scoreboard bench for task_link_ctrl: expected o_send cycles are queued as stimulus is driven
// and popped when the DUT pulses o_send; state/link/retry/fail are checked at key points.
module tb_task_link_ctrl;

  localparam int TO  = 8;
  localparam int HB  = 16;
  localparam int MR  = 3;
  localparam int BO  = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       done;
  logic       err;
  logic       send;
  logic       link;
  logic       fail;
  logic [2:0] state;
  logic [1:0] retry;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_send_q[$];

  task_link_ctrl #(
    .TIMEOUT_CYC  (TO),
    .HEARTBEAT_CYC(HB),
    .MAX_RETRY    (MR),
    .BACKOFF_CYC  (BO),
    .CNT_W        (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_enable(enable),
    .o_send  (send),
    .i_done  (done),
    .i_err   (err),
    .o_link  (link),
    .o_fail  (fail),
    .o_state (state),
    .o_retry (retry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Backoff cycles inserted before the retry that follows failure number r.
  function automatic int bo(input int r);
`ifdef TASK_LINK_BACKOFF_EN
    return BO << (r - 1);
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (send) begin
      if (exp_send_q.size() == 0) check("send_unexpected", 1, 0);
      else check("send_cycle", cyc, exp_send_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_send(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (send) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("send_wait_expired", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, l, s1, s2, s3, fcyc;
    bit dropped;
    rst_n = 1'b0; enable = 1'b0; done = 1'b0; err = 1'b0;
    #12 rst_n = 1'b1;
    step(1);
    check("rst_state", state, 0);
    check("rst_link", link, 0);
    check("rst_send", send, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry, 0);

    // Link-up: send 2 cycles after enable, done 5 cycles after send.
    enable = 1'b1;
    exp_send_q.push_back(cyc + 2);
    wait_send(10, s);
    step(4);
    done = 1'b1; step(1); done = 1'b0;
    check("up_link", link, 1);
    check("up_retry", retry, 0);
    check("up_state", state, 3);
    l = cyc;

    // Heartbeat: refresh send HB+1 cycles after LINKED entry, link held.
    exp_send_q.push_back(l + HB + 1);
    dropped = 0;
    r = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!link) dropped = 1;
      if (send) begin r = cyc; break; end
    end
    if (r < 0) check("hb_wait_expired", 0, 1);
    check("hb_link_held", dropped, 0);
    step(2);
    done = 1'b1; step(1); done = 1'b0;
    check("hb_state", state, 3);
    check("hb_retry", retry, 0);
    l = cyc;

    // Enable drop beats done during a refresh WAIT.
    exp_send_q.push_back(l + HB + 1);
    wait_send(40, r);
    step(1);
    enable = 1'b0; done = 1'b1;
    step(1);
    done = 1'b0;
    check("dis_state", state, 0);
    check("dis_link", link, 0);
    step(2);

    // Done + err on the timeout cycle: done wins.
    enable = 1'b1;
    exp_send_q.push_back(cyc + 2);
    wait_send(10, s);
    step(TO - 1);
    done = 1'b1; err = 1'b1; step(1); done = 1'b0; err = 1'b0;
    check("prio_state", state, 3);
    check("prio_retry", retry, 0);
    check("prio_link", link, 1);
    l = cyc;

    // Err is ignored while LINKED.
    err = 1'b1; step(1); err = 1'b0;
    check("lk_err_state", state, 3);
    check("lk_err_retry", retry, 0);

    // Refresh failure then async reset while o_send is high.
    exp_send_q.push_back(l + HB + 1);
    wait_send(40, r);
    #1 err = 1'b1;
    step(1);
    err = 1'b0;
    check("rf_retry", retry, 1);
    check("rf_link", link, 1);
    exp_send_q.push_back(r + 2 + bo(1));
    wait_send(20, s);
    #1 rst_n = 1'b0;
    #1;
    check("arst_link", link, 0);
    check("arst_send", send, 0);
    check("arst_retry", retry, 0);
    check("arst_state", state, 0);
    #1 rst_n = 1'b1;
    exp_send_q.push_back(cyc + 2);
    wait_send(10, s);
    step(1);
    done = 1'b1; step(1); done = 1'b0;
    check("rec_state", state, 3);
    enable = 1'b0;
    step(2);

    // Err-driven retries: send spacing reflects backoff (or none).
    enable = 1'b1;
    s1 = cyc + 2;
    exp_send_q.push_back(s1);
    wait_send(10, s);
    step(1);
    err = 1'b1; step(1); err = 1'b0;
    check("err1_retry", retry, 1);
    exp_send_q.push_back(s1 + 2 + 1 + bo(1));
    wait_send(40, s2);
    #1 err = 1'b1; step(1); err = 1'b0;
    check("err2_retry", retry, 2);
    exp_send_q.push_back(s2 + 1 + 1 + bo(2));
    wait_send(40, s3);
    step(1);
    done = 1'b1; step(1); done = 1'b0;
    check("err_rec_state", state, 3);
    check("err_rec_retry", retry, 0);
    enable = 1'b0;
    step(2);

    // Timeout to FAULT: three sends, each followed by a TO-cycle WAIT.
    enable = 1'b1;
    s1 = cyc + 2;
    s2 = s1 + TO + 1 + bo(1);
    s3 = s2 + TO + 1 + bo(2);
    exp_send_q.push_back(s1);
    exp_send_q.push_back(s2);
    exp_send_q.push_back(s3);
    fcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fail) begin fcyc = cyc; break; end
    end
    check("fault_cycle", fcyc, s3 + TO);
    check("fault_fail", fail, 1);
    check("fault_link", link, 0);
    check("fault_state", state, 4);
    check("fault_retry", retry, MR);
    step(5);
    check("fault_sticky", state, 4);
    enable = 1'b0;
    step(1);
    check("fault_exit_state", state, 0);
    check("fault_exit_fail", fail, 0);
    check("fault_exit_retry", retry, 0);
    step(3);

    check("sb_drained", exp_send_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
